// File: rtl/calc_core_param.sv
// Parametrised hex keypad calculator core: builds two operands from decoded
// key strobes, applies an ALU op, supports result chaining and drives an
// NDIG-digit seven-segment display.
module calc_core_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NDIG  = 2
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                key_valid,
  input  logic [4:0]          key_code,
  output logic [7*NDIG-1:0]   ss,
  output logic [WIDTH-1:0]    disp_val,
  output logic                result_valid,
  output logic                ovf,
  output logic                entering_b
);

  localparam int unsigned EXTW = (4 * NDIG > WIDTH) ? 4 * NDIG : WIDTH;

  typedef enum logic [1:0] {
    S_ENTER_A  = 2'd0,
    S_ENTER_B  = 2'd1,
    S_SHOW_RES = 2'd2
  } state_e;

  // Low three bits of the op key codes 0x10..0x14 map directly onto this enum.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic             rv_q, rv_d, ovf_q, ovf_d, eb_q, eb_d;

  logic             is_digit, is_op, is_enter, is_clear;
  logic [WIDTH-1:0] a_shift, b_shift, key_digit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [EXTW-1:0]  disp_ext;

  // Key decode; unlisted codes fall through every branch and change nothing.
  assign is_digit  = key_valid && (key_code[4] == 1'b0);
  assign is_op     = key_valid && (key_code >= 5'h10) && (key_code <= 5'h14);
  assign is_enter  = key_valid && (key_code == 5'h18);
  assign is_clear  = key_valid && (key_code == 5'h1F);
  assign key_digit = WIDTH'(key_code[3:0]);
  assign a_shift   = WIDTH'({a_q, key_code[3:0]});
  assign b_shift   = WIDTH'({b_q, key_code[3:0]});

  // ALU on the current operands; overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state and register updates for the entry/result state machine.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    rv_d    = 1'b0;
    if (is_clear) begin
      state_d = S_ENTER_A;
      op_d    = OP_ADD;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      disp_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (is_digit) begin
            a_d    = a_shift;
            disp_d = a_shift;
          end else if (is_op) begin
            op_d    = op_e'(key_code[2:0]);
            b_d     = '0;
            disp_d  = '0;
            state_d = S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (is_digit) begin
            b_d    = b_shift;
            disp_d = b_shift;
          end else if (is_op) begin
            op_d = op_e'(key_code[2:0]);
          end else if (is_enter) begin
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            disp_d  = alu_res;
            rv_d    = 1'b1;
            state_d = S_SHOW_RES;
          end
        end
        S_SHOW_RES: begin
          if (is_op) begin
            // Chain: previous result becomes the new first operand.
            a_d     = res_q;
            op_d    = op_e'(key_code[2:0]);
            b_d     = '0;
            state_d = S_ENTER_B;
          end else if (is_digit) begin
            a_d     = key_digit;
            disp_d  = key_digit;
            state_d = S_ENTER_A;
          end
        end
        default: state_d = S_ENTER_A;
      endcase
    end
    eb_d = (state_d == S_ENTER_B);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_ENTER_A;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      eb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
      eb_q    <= eb_d;
    end
  end

  assign disp_val     = disp_q;
  assign result_valid = rv_q;
  assign ovf          = ovf_q;
  assign entering_b   = eb_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Display nibbles beyond WIDTH read as zero.
  assign disp_ext = EXTW'(disp_q);

  for (genvar i = 0; i < int'(NDIG); i++) begin : g_digit
    assign ss[7*i +: 7] = hex7(disp_ext[4*i +: 4]);
  end

endmodule

// File: tb/tb_calc_core_param.sv
// Self-checking bench for calc_core_param: directed scenarios plus random key
// streams compared against an arithmetic reference model.
module tb_calc_core_param;

  localparam int W = 8;
  localparam int N = 2;
  localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_AND = 5'h12,
                         K_OR = 5'h13, K_XOR = 5'h14, K_ENT = 5'h18, K_CLR = 5'h1F;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           key_valid = 1'b0;
  logic [4:0]     key_code = 5'h0;
  logic [7*N-1:0] ss;
  logic [W-1:0]   disp_val;
  logic           result_valid, ovf, entering_b;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;

  calc_core_param #(.WIDTH(W), .NDIG(N)) dut (
    .clk(clk), .nrst(nrst), .key_valid(key_valid), .key_code(key_code),
    .ss(ss), .disp_val(disp_val), .result_valid(result_valid),
    .ovf(ovf), .entering_b(entering_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) rv_count++;

  // Reference model: mode 0 = entering A, 1 = entering B, 2 = showing result.
  int     m_mode;
  longint m_a, m_b, m_res, m_disp;
  int     m_op;
  bit     m_ovf, m_rv;
  int     m_rv_total = 0;
  longint MOD = longint'(1) << W;

  function automatic longint to_signed(input longint v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_disp = 0; m_op = 0;
    m_ovf = 0; m_rv = 0;
  endtask

  task automatic model_key(input logic [4:0] code);
    longint s;
    m_rv = 0;
    if (code == K_CLR) begin
      model_reset();
    end else if (code < 5'h10) begin
      if (m_mode == 0) begin m_a = (m_a * 16 + code) % MOD; m_disp = m_a; end
      else if (m_mode == 1) begin m_b = (m_b * 16 + code) % MOD; m_disp = m_b; end
      else begin m_a = code; m_disp = m_a; m_mode = 0; end
    end else if (code <= 5'h14) begin
      if (m_mode == 0) begin m_op = code - 16; m_b = 0; m_disp = 0; m_mode = 1; end
      else if (m_mode == 1) m_op = code - 16;
      else begin m_a = m_res; m_op = code - 16; m_b = 0; m_mode = 1; end
    end else if (code == K_ENT && m_mode == 1) begin
      m_ovf = 0;
      case (m_op)
        0: begin s = to_signed(m_a) + to_signed(m_b); m_res = (m_a + m_b) % MOD;
                 m_ovf = (s >= MOD / 2) || (s < -(MOD / 2)); end
        1: begin s = to_signed(m_a) - to_signed(m_b); m_res = (m_a - m_b + MOD) % MOD;
                 m_ovf = (s >= MOD / 2) || (s < -(MOD / 2)); end
        2: m_res = m_a & m_b;
        3: m_res = m_a | m_b;
        default: m_res = m_a ^ m_b;
      endcase
      m_disp = m_res; m_mode = 2; m_rv = 1; m_rv_total++;
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [7*N-1:0] exp_ss();
    logic [7*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[7*i +: 7] = glyph(int'((m_disp >> (4 * i)) & 15));
    return r;
  endfunction

  // One key strobe lasting exactly one cycle; consecutive calls give back-to-back strobes.
  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1; key_code = code;
    model_key(code);
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 5'h0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    m_rv = 0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (disp_val !== 8'h00) begin errors++; $display("FAIL reset_disp got %h want 00", disp_val); end
    checks++; if (ss !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL reset_ss got %h want %h", ss, {7'h3F, 7'h3F}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (entering_b !== 1'b0) begin errors++; $display("FAIL reset_eb got %b want 0", entering_b); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", result_valid); end
  endtask

  task automatic test_add_basic();
    press(5'h3); press(K_ADD);
    checks++; if (entering_b !== 1'b1) begin errors++; $display("FAIL add_eb got %b want 1", entering_b); end
    checks++; if (disp_val !== 8'h00) begin errors++; $display("FAIL add_disp_op got %h want 00", disp_val); end
    press(5'h5); press(K_ENT);
    checks++; if (disp_val !== 8'h08) begin errors++; $display("FAIL add_res got %h want 08", disp_val); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add_rv_hi got %b want 1", result_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got %b want 0", ovf); end
    checks++; if (entering_b !== 1'b0) begin errors++; $display("FAIL add_eb_res got %b want 0", entering_b); end
    idle();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_rv_lo got %b want 0", result_valid); end
  endtask

  task automatic test_overflow();
    press(5'h7); press(5'hF); press(K_ADD); press(5'h0); press(5'h1); press(K_ENT);
    checks++; if (disp_val !== 8'h80) begin errors++; $display("FAIL ovf_add_res got %h want 80", disp_val); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_flag got %b want 1", ovf); end
    checks++; if (ss !== {7'h7F, 7'h3F}) begin errors++; $display("FAIL ovf_ss got %h want %h", ss, {7'h7F, 7'h3F}); end
    press(5'h0); press(5'h5);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", ovf); end
    press(K_SUB); press(5'h0); press(5'h7); press(K_ENT);
    checks++; if (disp_val !== 8'hFE) begin errors++; $display("FAIL sub_res got %h want FE", disp_val); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b want 0", ovf); end
  endtask

  task automatic test_chain();
    press(5'h2); press(K_ADD); press(5'h3); press(K_ENT);
    checks++; if (disp_val !== 8'h05) begin errors++; $display("FAIL chain_first got %h want 05", disp_val); end
    press(K_SUB);
    checks++; if (entering_b !== 1'b1) begin errors++; $display("FAIL chain_eb got %b want 1", entering_b); end
    press(5'h1); press(K_ENT);
    checks++; if (disp_val !== 8'h04) begin errors++; $display("FAIL chain_second got %h want 04", disp_val); end
    press(5'h9);
    checks++; if (disp_val !== 8'h09) begin errors++; $display("FAIL chain_digit got %h want 09", disp_val); end
    checks++; if (entering_b !== 1'b0) begin errors++; $display("FAIL chain_enter_a got %b want 0", entering_b); end
  endtask

  task automatic test_truncation();
    press(5'h1); press(5'h2); press(5'h3);
    checks++; if (disp_val !== 8'h23) begin errors++; $display("FAIL trunc got %h want 23", disp_val); end
    press(5'h1); press(5'h2); press(K_ADD); press(K_CLR);
    checks++; if (disp_val !== 8'h00) begin errors++; $display("FAIL clr_disp got %h want 00", disp_val); end
    checks++; if (entering_b !== 1'b0) begin errors++; $display("FAIL clr_eb got %b want 0", entering_b); end
    checks++; if (ss !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL clr_ss got %h want %h", ss, {7'h3F, 7'h3F}); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_count;
    press(5'hA); press(K_XOR); press(5'h5); press(K_ENT);
    checks++; if (disp_val !== 8'h0F) begin errors++; $display("FAIL b2b_res got %h want 0F", disp_val); end
    press(K_ENT); press(K_ENT); idle();
    checks++; if (rv_count - rv0 !== 1) begin errors++; $display("FAIL b2b_rv_pulses got %0d want 1", rv_count - rv0); end
    checks++; if (disp_val !== 8'h0F) begin errors++; $display("FAIL b2b_hold got %h want 0F", disp_val); end
  endtask

  task automatic test_reset_mid();
    int rv0;
    rv0 = rv_count;
    press(5'h1); press(K_AND); press(5'h4);
    @(negedge clk); nrst = 1'b0; #1;
    model_reset();
    checks++; if (disp_val !== 8'h00) begin errors++; $display("FAIL midrst_disp got %h want 00", disp_val); end
    checks++; if (entering_b !== 1'b0) begin errors++; $display("FAIL midrst_eb got %b want 0", entering_b); end
    checks++; if (ss !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL midrst_ss got %h want %h", ss, {7'h3F, 7'h3F}); end
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    idle();
    checks++; if (rv_count !== rv0) begin errors++; $display("FAIL midrst_rv got %0d want %0d", rv_count, rv0); end
  endtask

  task automatic test_random();
    logic [4:0] code;
    logic [4:0] ign [5] = '{5'h15, 5'h16, 5'h17, 5'h19, 5'h1E};
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      code = 5'($urandom_range(0, 15));
      else if (r < 75) code = 5'(5'h10 + $urandom_range(0, 4));
      else if (r < 89) code = K_ENT;
      else if (r < 92) code = K_CLR;
      else             code = ign[$urandom_range(0, 4)];
      press(code);
      if ($urandom_range(0, 7) == 0) idle();
      checks++; if (disp_val !== W'(m_disp)) begin errors++; $display("FAIL rnd_disp i=%0d got %h want %h", i, disp_val, W'(m_disp)); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf i=%0d got %b want %b", i, ovf, m_ovf); end
      checks++; if (entering_b !== (m_mode == 1)) begin errors++; $display("FAIL rnd_eb i=%0d got %b want %b", i, entering_b, m_mode == 1); end
      checks++; if (result_valid !== m_rv) begin errors++; $display("FAIL rnd_rv i=%0d got %b want %b", i, result_valid, m_rv); end
      checks++; if (ss !== exp_ss()) begin errors++; $display("FAIL rnd_ss i=%0d got %h want %h", i, ss, exp_ss()); end
    end
    idle();
    checks++; if (rv_count !== m_rv_total) begin errors++; $display("FAIL rnd_rv_total got %0d want %0d", rv_count, m_rv_total); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_basic();
    test_overflow();
    test_chain();
    test_truncation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
